// File: rtl/cancid_ctx_pkg.sv
// Shared types and helpers for the stream-context block.
package cancid_ctx_pkg;

    // Context FSM: idle between packets, run while a packet is streaming.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ctx_state_e;

    // Counters are computed through a 32-bit helper, so COUNT_W must not exceed this.
    localparam int unsigned CntMaxW = 32;

    // Increment v by one, holding at the all-ones value of a w-bit counter.
    function automatic logic [CntMaxW-1:0] sat_inc(input logic [CntMaxW-1:0] v,
                                                   input int unsigned w);
        logic [CntMaxW-1:0] max_v;
        max_v = (w >= CntMaxW) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cancid_ctx_ram.sv
// 1R1W synchronous state store; a same-address write is forwarded to the read.
module cancid_ctx_ram #(
    parameter  int unsigned DEPTH = 64,
    parameter  int unsigned WIDTH = 11,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port plus registered, write-first read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cancid_stream_ctx.sv
// Per-stream DFA context save/restore with saturating per-stream match counters.
// Optional: define CANCID_CTX_CLEAR_ON_READ_EN to make counter reads destructive.
module cancid_stream_ctx
    import cancid_ctx_pkg::*;
#(
    parameter  int unsigned NUM_STREAMS = 64,
    parameter  int unsigned STATE_W     = 11,
    parameter  int unsigned COUNT_W     = 16,
    localparam int unsigned SID_W       = $clog2(NUM_STREAMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   pkt_sid,
    input  logic               pkt_new,
    input  logic               pkt_enable,
    input  logic               eop,
    input  logic               dfa_accept,
    input  logic [STATE_W-1:0] dfa_state_out,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    output logic               ctx_ready,
    output logic               match_fired,
    output logic               proto_err,
    input  logic               cnt_rd_en,
    input  logic [SID_W-1:0]   cnt_rd_sid,
    output logic [COUNT_W-1:0] cnt_rd_data,
    output logic               cnt_rd_vld
);

    ctx_state_e         state_q, state_d;
    logic [SID_W-1:0]   sid_q;
    logic               new_q, enable_q, flag_q;
    logic               load_vld_q, match_q, err_q;
    logic [NUM_STREAMS-1:0] valid_q;
    logic [COUNT_W-1:0] cnt_q [NUM_STREAMS];
    logic [COUNT_W-1:0] cnt_rd_q;
    logic               cnt_rd_vld_q;
    logic [STATE_W-1:0] ram_rdata;

    logic               start_ok, commit, commit_wr, hit;
    logic [CntMaxW-1:0] cnt_inc;
    logic [COUNT_W-1:0] cnt_new, cnt_rd_cur;

    // Decode packet boundaries and the committed counter value.
    always_comb begin
        start_ok   = pkt_start && (state_q == StIdle);
        commit     = eop && (state_q == StRun);
        commit_wr  = commit && enable_q;
        hit        = flag_q || dfa_accept;
        cnt_inc    = sat_inc(CntMaxW'(cnt_q[sid_q]), COUNT_W);
        cnt_new    = hit ? cnt_inc[COUNT_W-1:0] : cnt_q[sid_q];
        // A commit to the addressed stream in the read cycle is bypassed to the reader.
        cnt_rd_cur = (commit_wr && (sid_q == cnt_rd_sid)) ? cnt_new : cnt_q[cnt_rd_sid];
    end

    // Next-state logic: pkt_start only opens a packet from idle, eop only closes one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pkt_start) state_d = StRun;
            StRun:   if (eop)       state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, packet attributes, speculative match flag, strobes and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sid_q      <= '0;
            new_q      <= 1'b0;
            enable_q   <= 1'b0;
            flag_q     <= 1'b0;
            load_vld_q <= 1'b0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_vld_q <= start_ok;
            match_q    <= commit_wr && hit;
            err_q      <= err_q || (pkt_start && (state_q == StRun))
                                || (eop && (state_q == StIdle));
            if (start_ok) begin
                sid_q    <= pkt_sid;
                new_q    <= pkt_new;
                enable_q <= pkt_enable;
                flag_q   <= 1'b0;
            end else if ((state_q == StRun) && dfa_accept) begin
                flag_q   <= 1'b1;
            end
        end
    end

    // Valid bits and counters; a destructive read wins over a same-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (commit_wr) begin
                valid_q[sid_q] <= 1'b1;
                cnt_q[sid_q]   <= cnt_new;
            end
`ifdef CANCID_CTX_CLEAR_ON_READ_EN
            if (cnt_rd_en) begin
                cnt_q[cnt_rd_sid] <= '0;
            end
`endif
        end
    end

    // Registered counter read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd_q     <= '0;
            cnt_rd_vld_q <= 1'b0;
        end else begin
            cnt_rd_vld_q <= cnt_rd_en;
            if (cnt_rd_en) begin
                cnt_rd_q <= cnt_rd_cur;
            end
        end
    end

    cancid_ctx_ram #(
        .DEPTH (NUM_STREAMS),
        .WIDTH (STATE_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit_wr),
        .waddr (sid_q),
        .wdata (dfa_state_out),
        .re    (start_ok),
        .raddr (pkt_sid),
        .rdata (ram_rdata)
    );

    // Saved state is only trusted for a known, non-new stream.
    always_comb begin
        dfa_state_in = '0;
        if (load_vld_q && !new_q && valid_q[sid_q]) begin
            dfa_state_in = ram_rdata;
        end
    end

    assign dfa_state_in_vld = load_vld_q;
    assign ctx_ready        = (state_q == StIdle);
    assign match_fired      = match_q;
    assign proto_err        = err_q;
    assign cnt_rd_data      = cnt_rd_q;
    assign cnt_rd_vld       = cnt_rd_vld_q;

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Directed bench for cancid_stream_ctx: a default instance plus a COUNT_W=2 instance
// sharing the same stimulus for the saturation case.
module tb_cancid_stream_ctx;

`ifdef CANCID_CTX_CLEAR_ON_READ_EN
    localparam bit Clr = 1'b1;
`else
    localparam bit Clr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_start = 1'b0, pkt_new = 1'b0, pkt_enable = 1'b0;
    logic [5:0]  pkt_sid = '0, cnt_rd_sid = '0;
    logic        eop = 1'b0, dfa_accept = 1'b0, cnt_rd_en = 1'b0;
    logic [10:0] dfa_state_out = '0;

    logic [10:0] dfa_state_in, dfa_state_in_s;
    logic        load_vld, ready, match, err, rd_vld;
    logic        load_vld_s, ready_s, match_s, err_s, rd_vld_s;
    logic [15:0] rd_data;
    logic [1:0]  rd_data_s;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    cancid_stream_ctx dut (
        .clk (clk), .rst_n (rst_n), .pkt_start (pkt_start), .pkt_sid (pkt_sid),
        .pkt_new (pkt_new), .pkt_enable (pkt_enable), .eop (eop), .dfa_accept (dfa_accept),
        .dfa_state_out (dfa_state_out), .dfa_state_in (dfa_state_in),
        .dfa_state_in_vld (load_vld), .ctx_ready (ready), .match_fired (match),
        .proto_err (err), .cnt_rd_en (cnt_rd_en), .cnt_rd_sid (cnt_rd_sid),
        .cnt_rd_data (rd_data), .cnt_rd_vld (rd_vld)
    );

    cancid_stream_ctx #(.COUNT_W (2)) dut_sat (
        .clk (clk), .rst_n (rst_n), .pkt_start (pkt_start), .pkt_sid (pkt_sid),
        .pkt_new (pkt_new), .pkt_enable (pkt_enable), .eop (eop), .dfa_accept (dfa_accept),
        .dfa_state_out (dfa_state_out), .dfa_state_in (dfa_state_in_s),
        .dfa_state_in_vld (load_vld_s), .ctx_ready (ready_s), .match_fired (match_s),
        .proto_err (err_s), .cnt_rd_en (cnt_rd_en), .cnt_rd_sid (cnt_rd_sid),
        .cnt_rd_data (rd_data_s), .cnt_rd_vld (rd_vld_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [5:0] sid, input logic is_new, input logic en);
        pkt_start = 1'b1; pkt_sid = sid; pkt_new = is_new; pkt_enable = en;
        step();
        pkt_start = 1'b0;
    endtask

    task automatic end_pkt(input logic [10:0] st, input logic acc);
        eop = 1'b1; dfa_state_out = st; dfa_accept = acc;
        step();
        eop = 1'b0; dfa_accept = 1'b0;
    endtask

    task automatic rd(input logic [5:0] sid);
        cnt_rd_en = 1'b1; cnt_rd_sid = sid;
        step();
        cnt_rd_en = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_ready", ready, 1);
        check("rst_load_vld", load_vld, 0);
        check("rst_state_in", dfa_state_in, 0);
        check("rst_match", match, 0);
        check("rst_err", err, 0);
        check("rst_rd_vld", rd_vld, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Unknown stream loads state 0, strobe lasts one cycle
        start_pkt(6'd5, 1'b0, 1'b1);
        check("s5_load_vld", load_vld, 1);
        check("s5_state_in", dfa_state_in, 0);
        check("s5_ready_run", ready, 0);
        step();
        check("s5_load_vld_off", load_vld, 0);
        end_pkt(11'h11, 1'b0);
        check("s5_no_match", match, 0);
        check("s5_ready_idle", ready, 1);
        rd(6'd5);
        check("s5_rd_vld", rd_vld, 1);
        check("s5_cnt", rd_data, 0);

        // Enabled packet with an earlier accept commits state and count
        start_pkt(6'd3, 1'b0, 1'b1);
        check("a_state_in", dfa_state_in, 0);
        step();
        dfa_accept = 1'b1; step(); dfa_accept = 1'b0;
        step();
        end_pkt(11'h2A, 1'b0);
        check("a_match", match, 1);
        step();
        check("a_match_pulse", match, 0);
        rd(6'd3);
        check("a_cnt", rd_data, 1);

        // Restore saved state; accept on eop; read bypass in commit cycle
        start_pkt(6'd3, 1'b0, 1'b1);
        check("b_state_in", dfa_state_in, 11'h2A);
        step();
        eop = 1'b1; dfa_state_out = 11'h15; dfa_accept = 1'b1;
        cnt_rd_en = 1'b1; cnt_rd_sid = 6'd3;
        step();
        eop = 1'b0; dfa_accept = 1'b0; cnt_rd_en = 1'b0;
        pkt_start = 1'b1; pkt_sid = 6'd3; pkt_new = 1'b0; pkt_enable = 1'b0;
        check("b_match_eop_accept", match, 1);
        check("b_ready", ready, 1);
        check("b_rd_vld", rd_vld, 1);
        check("b_cnt_bypass", rd_data, Clr ? 1 : 2);
        step();
        pkt_start = 1'b0;
        check("c_load_vld", load_vld, 1);
        check("c_state_in_wf", dfa_state_in, 11'h15);
        rd(6'd3);
        check("c_cnt_reread", rd_data, Clr ? 0 : 2);

        // Disabled packet: flag discarded, nothing committed
        dfa_accept = 1'b1; step(); dfa_accept = 1'b0;
        end_pkt(11'h3F, 1'b1);
        check("c_no_match", match, 0);
        rd(6'd3);
        check("c_cnt_kept", rd_data, Clr ? 0 : 2);
        start_pkt(6'd3, 1'b1, 1'b0);
        check("d_new_state_in", dfa_state_in, 0);
        step();
        end_pkt(11'h00, 1'b0);
        start_pkt(6'd3, 1'b0, 1'b0);
        check("e_state_in_kept", dfa_state_in, 11'h15);
        step();
        end_pkt(11'h00, 1'b0);

        // Disabled packet on a fresh stream leaves it invalid
        start_pkt(6'd9, 1'b0, 1'b0);
        step();
        dfa_accept = 1'b1; step(); dfa_accept = 1'b0;
        end_pkt(11'h2A, 1'b0);
        check("s9_no_match", match, 0);
        rd(6'd9);
        check("s9_cnt", rd_data, 0);
        start_pkt(6'd9, 1'b0, 1'b1);
        check("s9_state_in", dfa_state_in, 0);
        step();
        end_pkt(11'h01, 1'b0);

        // Four matching packets: 16-bit counter reaches 4, 2-bit counter holds at 3
        for (int i = 0; i < 4; i++) begin
            start_pkt(6'd7, 1'b0, 1'b1);
            step();
            end_pkt(11'(i), 1'b1);
        end
        rd(6'd7);
        check("s7_cnt16", rd_data, 4);
        check("s7_cnt2_sat", rd_data_s, 3);
        check("s7_err_clean", err, 0);

        // eop while idle is ignored and sets the sticky error
        eop = 1'b1; step(); eop = 1'b0;
        check("idle_eop_err", err, 1);
        check("idle_eop_ready", ready, 1);
        check("idle_eop_match", match, 0);
        step(); step();
        check("err_sticky", err, 1);

        // Reset clears the error
        rst_n = 1'b0;
        #2;
        check("rst2_err", err, 0);
        step();
        rst_n = 1'b1;
        step();

        // pkt_start while running, then eop and pkt_start together
        start_pkt(6'd2, 1'b0, 1'b1);
        pkt_start = 1'b1; pkt_sid = 6'd4;
        step();
        pkt_start = 1'b0;
        check("run_start_err", err, 1);
        check("run_start_no_load", load_vld, 0);
        eop = 1'b1; pkt_start = 1'b1; pkt_sid = 6'd4; dfa_accept = 1'b1; dfa_state_out = 11'h07;
        step();
        eop = 1'b0; pkt_start = 1'b0; dfa_accept = 1'b0;
        check("both_match", match, 1);
        check("both_ready", ready, 1);
        step();
        check("both_no_load", load_vld, 0);
        check("both_still_idle", ready, 1);
        rd(6'd2);
        check("s2_cnt", rd_data, 1);

        // Reset mid-packet abandons it and clears counters and valid bits
        start_pkt(6'd6, 1'b0, 1'b1);
        step();
        dfa_accept = 1'b1; step(); dfa_accept = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst3_ready", ready, 1);
        step();
        rst_n = 1'b1;
        step();
        rd(6'd2);
        check("rst3_cnt2", rd_data, 0);
        rd(6'd6);
        check("rst3_cnt6", rd_data, 0);
        start_pkt(6'd2, 1'b0, 1'b1);
        check("rst3_state_in", dfa_state_in, 0);
        step();
        end_pkt(11'h00, 1'b0);
        check("rst3_no_match", match, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
